// File: rtl/udp_tx_arbiter_pkg.sv
// Shared definitions for the UDP transmit arbiter: FSM state encoding and
// UDP header field/width constants.
package udp_pkg;

  localparam int unsigned UDP_FIELD_W = 16;
  localparam int unsigned UDP_HDR_W   = 3 * UDP_FIELD_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/udp_tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted request strictly after
// i_last (wrapping around), plus an any-request flag.
module rr_arbiter #(
  parameter int unsigned NUM_SOURCES = 2
) (
  input  logic [NUM_SOURCES-1:0]         i_req,
  input  logic [$clog2(NUM_SOURCES)-1:0] i_last,
  output logic [$clog2(NUM_SOURCES)-1:0] o_grant,
  output logic                           o_any
);

  localparam int unsigned IDX_W = $clog2(NUM_SOURCES);

  logic w_hi_found;
  logic w_lo_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Two constant-indexed passes instead of a modulo index: indices above
  // i_last take priority over the wrapped-around ones.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
      if (i_req[j]) begin
        if (j > 32'(i_last)) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = IDX_W'(j);
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDX_W'(j);
        end
      end
    end
  end

  assign o_any   = w_hi_found | w_lo_found;
  assign o_grant = w_hi_found ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP checksum generator between several
// header+payload requesters; grant held from header entry to tlast.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 2,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SOURCES-1:0]            src_hdr_valid,
  output logic [NUM_SOURCES-1:0]            src_hdr_ready,
  input  logic [UDP_HDR_W*NUM_SOURCES-1:0]  src_hdr,
  input  logic [DATA_WIDTH*NUM_SOURCES-1:0] src_tdata,
  input  logic [NUM_SOURCES-1:0]            src_tvalid,
  input  logic [NUM_SOURCES-1:0]            src_tlast,
  output logic [NUM_SOURCES-1:0]            src_tready,
  output logic                              out_hdr_valid,
  input  logic                              out_hdr_ready,
  output logic [UDP_HDR_W-1:0]              out_hdr,
  output logic [DATA_WIDTH-1:0]             out_tdata,
  output logic                              out_tvalid,
  output logic                              out_tlast,
  input  logic                              out_tready,
  output logic [$clog2(NUM_SOURCES)-1:0]    grant_id,
  output logic                              busy
);

  localparam int unsigned IDX_W = $clog2(NUM_SOURCES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_last_nxt;

  logic [IDX_W-1:0]       w_rr_grant;
  logic                   w_rr_any;
  logic [NUM_SOURCES-1:0] w_grant_oh;
  logic [UDP_HDR_W-1:0]   w_hdr_sel;
  logic                   w_hdr_vld_sel;
  logic [DATA_WIDTH-1:0]  w_tdata_sel;
  logic                   w_tvalid_sel;
  logic                   w_tlast_sel;

  rr_arbiter #(
    .NUM_SOURCES(NUM_SOURCES)
  ) u_rr (
    .i_req   (src_hdr_valid),
    .i_last  (r_last_grant),
    .o_grant (w_rr_grant),
    .o_any   (w_rr_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_SOURCES - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  always_comb begin
    w_grant_oh    = '0;
    w_hdr_sel     = '0;
    w_hdr_vld_sel = 1'b0;
    w_tdata_sel   = '0;
    w_tvalid_sel  = 1'b0;
    w_tlast_sel   = 1'b0;
    for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
      if (r_grant == IDX_W'(j)) begin
        w_grant_oh[j] = 1'b1;
        w_hdr_sel     = src_hdr[j*UDP_HDR_W +: UDP_HDR_W];
        w_hdr_vld_sel = src_hdr_valid[j];
        w_tdata_sel   = src_tdata[j*DATA_WIDTH +: DATA_WIDTH];
        w_tvalid_sel  = src_tvalid[j];
        w_tlast_sel   = src_tlast[j];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last_grant;
    src_hdr_ready = '0;
    src_tready    = '0;
    out_hdr_valid = 1'b0;
    out_hdr       = '0;
    out_tvalid    = 1'b0;
    out_tdata     = '0;
    out_tlast     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rr_any) begin
          w_state_nxt = ST_HEADER;
          w_grant_nxt = w_rr_grant;
          w_last_nxt  = w_rr_grant;
        end
      end
      ST_HEADER: begin
        out_hdr_valid = w_hdr_vld_sel;
        out_hdr       = w_hdr_vld_sel ? w_hdr_sel : '0;
        if (out_hdr_ready) src_hdr_ready = w_grant_oh;
        if (w_hdr_vld_sel && out_hdr_ready) w_state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        out_tvalid = w_tvalid_sel;
        out_tdata  = w_tvalid_sel ? w_tdata_sel : '0;
        out_tlast  = w_tvalid_sel & w_tlast_sel;
        if (out_tready) src_tready = w_grant_oh;
        if (w_tvalid_sel && w_tlast_sel && out_tready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != ST_IDLE);

endmodule
